// File: rtl/spi_block_if.sv
// Host command/status bus for spi_block.
//   wr       : one-cycle command strobe (host -> block)
//   data_in  : command word, sampled while wr=1 (host -> block)
//   data_out : registered status and last popped byte (block -> host)
interface spi_block_if;
  logic        wr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output wr, output data_in, input data_out);
  modport slave  (input wr, input data_in, output data_out);
endinterface

// File: rtl/spi_block.sv
// SPI mode-0 slave receiver (MSB first) feeding a byte FIFO that the host
// drains through write-strobed commands.
// Ports:
//   clk, rst         : system clock, synchronous active-high reset
//   ss, sclk, mosi   : asynchronous SPI pins, oversampled by clk
//   host (slave)     : wr / data_in command strobe, data_out status word
//                      {full, empty, overflow, 11'b0, count[9:0], byte[7:0]}
//   full_alarm_led   : FIFO full
//   empty_alarm_led  : FIFO empty
module spi_block #(
  parameter int DEPTH      = 512,
  parameter int ADDR_W     = 9,
  parameter int FRAME_BITS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ss,
  input  logic          sclk,
  input  logic          mosi,
  spi_block_if.slave    host,
  output logic          full_alarm_led,
  output logic          empty_alarm_led
);

  localparam int                CNT_W     = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_BITS - 1);
  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH);
  // Idle levels of {mosi, sclk, ss}: slave deselected, clock low.
  localparam logic [2:0]        SYNC_IDLE = 3'b001;

  // ---------------------------------------------------------------------
  // Two-flop synchronizers for the three SPI pins
  // ---------------------------------------------------------------------
  logic [2:0] pins_raw;
  logic [2:0] pins_sync;
  assign pins_raw = {mosi, sclk, ss};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    logic meta_reg;
    logic stage_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        meta_reg  <= SYNC_IDLE[gi];
        stage_reg <= SYNC_IDLE[gi];
      end else begin
        meta_reg  <= pins_raw[gi];
        stage_reg <= meta_reg;
      end
    end
    assign pins_sync[gi] = stage_reg;
  end

  logic ss_s, sclk_s, mosi_s;
  assign ss_s   = pins_sync[0];
  assign sclk_s = pins_sync[1];
  assign mosi_s = pins_sync[2];

  logic sclk_prev_reg;
  logic sclk_rise;
  assign sclk_rise = sclk_s & ~sclk_prev_reg;

  // ---------------------------------------------------------------------
  // Bit assembly. A finished frame raises push_req_reg for one cycle; the
  // completed byte is still sitting in shift_reg on that cycle.
  // ---------------------------------------------------------------------
  logic [FRAME_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt_reg;
  logic                  push_req_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_reg <= 1'b0;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      push_req_reg  <= 1'b0;
    end else begin
      sclk_prev_reg <= sclk_s;
      push_req_reg  <= 1'b0;
      if (ss_s) begin
        // Deselect throws away any partial frame.
        bit_cnt_reg <= '0;
        shift_reg   <= '0;
      end else if (sclk_rise) begin
        shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_s};
        if (bit_cnt_reg == LAST_BIT) begin
          bit_cnt_reg  <= '0;
          push_req_reg <= 1'b1;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [FRAME_BITS-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]       count_reg, count_next;
  logic                  ovf_reg;
  logic                  full_flag_reg, empty_flag_reg;
  logic [FRAME_BITS-1:0] byte_reg;

  logic pop_cmd, clr_cmd, is_full, is_empty, pop_ok, push_ok;
  assign pop_cmd  = host.wr &  host.data_in[31];
  assign clr_cmd  = host.wr & ~host.data_in[31];
  assign is_full  = (count_reg == CNT_FULL);
  assign is_empty = (count_reg == '0);
  assign pop_ok   = pop_cmd & ~is_empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push_ok  = push_req_reg & (~is_full | pop_ok);

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      ovf_reg        <= 1'b0;
      full_flag_reg  <= 1'b0;
      empty_flag_reg <= 1'b1;
    end else begin
      count_reg      <= count_next;
      full_flag_reg  <= (count_next == CNT_FULL);
      empty_flag_reg <= (count_next == '0);
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // A dropped byte wins over a clear arriving in the same cycle.
      if (push_req_reg && !push_ok) ovf_reg <= 1'b1;
      else if (clr_cmd)             ovf_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge clk) begin
    if (rst)         byte_reg <= '0;
    else if (pop_ok) byte_reg <= mem[rd_ptr_reg];
  end

  assign host.data_out   = {full_flag_reg, empty_flag_reg, ovf_reg, 11'b0,
                            10'(count_reg), 8'(byte_reg)};
  assign full_alarm_led  = full_flag_reg;
  assign empty_alarm_led = empty_flag_reg;

endmodule

// File: tb/tb_spi_block.sv
// Directed bench for spi_block: drives SPI frames on the pins and host
// commands on the interface, compares against hand-computed values.
module tb_spi_block;
  logic clk = 1'b0;
  logic rst, ss, sclk, mosi;
  logic full_alarm_led, empty_alarm_led;
  int   errors = 0;
  int   checks = 0;

  spi_block_if host ();

  spi_block dut (
    .clk             (clk),
    .rst             (rst),
    .ss              (ss),
    .sclk            (sclk),
    .mosi            (mosi),
    .host            (host.slave),
    .full_alarm_led  (full_alarm_led),
    .empty_alarm_led (empty_alarm_led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Send the top n bits of b, MSB first, 50 ns sclk high/low.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      #50 sclk = 1'b1;
      #50 sclk = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic host_cmd(input logic [31:0] w);
    @(negedge clk);
    host.wr      = 1'b1;
    host.data_in = w;
    @(negedge clk);
    host.wr      = 1'b0;
    host.data_in = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    host.wr = 1'b0; host.data_in = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    settle();
    check("reset data_out", host.data_out, 32'h4000_0000);
    check("reset empty_led", 32'(empty_alarm_led), 32'd1);
    check("reset full_led", 32'(full_alarm_led), 32'd0);

    // Single frame 0x1F, ss stays low afterwards
    ss = 1'b0; #100;
    send_bits(8'h1F, 8);
    settle();
    check("frame1 data_out", host.data_out, 32'h0000_0100);
    check("frame1 empty_led", 32'(empty_alarm_led), 32'd0);
    host_cmd(32'h8000_0000);
    check("pop 1F", host.data_out, 32'h4000_001F);

    // Back-to-back frames without raising ss
    send_bits(8'h1F, 8);
    send_bits(8'hF3, 8);
    settle();
    check("two frames count", host.data_out, 32'h0000_021F);
    host_cmd(32'h8000_0000);
    check("pop order 1F", host.data_out, 32'h0000_011F);
    host_cmd(32'h8000_0000);
    check("pop order F3", host.data_out, 32'h4000_00F3);
    host_cmd(32'h8000_0000);
    check("pop empty ignored", host.data_out, 32'h4000_00F3);

    // Overflow: 522 frames of bytes 0,1,2,... into a 512-deep FIFO
    for (int i = 0; i < 522; i++) begin
      send_bits(8'(i), 8);
    end
    settle();
    ss = 1'b1;
    check("overflow data_out", host.data_out, 32'hA002_00F3);
    check("overflow full_led", 32'(full_alarm_led), 32'd1);
    check("overflow empty_led", 32'(empty_alarm_led), 32'd0);

    host_cmd(32'h0000_0000);
    check("clear overflow", host.data_out, 32'h8002_00F3);
    host_cmd(32'h8000_0000);
    check("drain pop 1", host.data_out, 32'h0001_FF00);
    check("drain full_led", 32'(full_alarm_led), 32'd0);
    host_cmd(32'h8000_0000);
    check("drain pop 2", host.data_out, 32'h0001_FE01);

    pulse_reset();
    check("reset after drain", host.data_out, 32'h4000_0000);

    // Partial frame aborted by ss, then a full 0xA5 frame
    settle();
    ss = 1'b0; #100;
    send_bits(8'hC0, 4);
    #100 ss = 1'b1;
    #200 ss = 1'b0;
    #100;
    send_bits(8'hA5, 8);
    #100 ss = 1'b1;
    settle();
    check("abort count", host.data_out, 32'h0000_0100);
    host_cmd(32'h8000_0000);
    check("abort pop A5", host.data_out, 32'h4000_00A5);

    // Reset in the middle of a frame: partial bits must be lost
    ss = 1'b0; #100;
    send_bits(8'hF0, 4);
    pulse_reset();
    send_bits(8'h0F, 4);
    #100 ss = 1'b1;
    settle();
    check("midreset data_out", host.data_out, 32'h4000_0000);
    check("midreset empty_led", 32'(empty_alarm_led), 32'd1);
    #200 ss = 1'b0;
    #100;
    send_bits(8'h3C, 8);
    #100 ss = 1'b1;
    settle();
    host_cmd(32'h8000_0000);
    check("post reset pop 3C", host.data_out, 32'h4000_003C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_block.md
Name: spi_block

Overview:
- SPI slave receiver (mode 0, MSB first, 8-bit frames) feeding a byte FIFO, with a 32-bit host command/status interface and two alarm LEDs.
- Sits between an external SPI master (asynchronous sclk/ss/mosi pins) and an on-chip host that drains received bytes via write-strobed commands.
- All logic runs in the single system clock domain; SPI pins are oversampled.

Parameters:
- DEPTH, 512, FIFO capacity in bytes (power of two).
- ADDR_W, 9, log2(DEPTH).
- FRAME_BITS, 8, bits per SPI frame.

Ports:
- clk  input  1  system clock; must be at least 8x the sclk frequency.
- rst  input  1  synchronous, active-high reset.
- ss  input  1  SPI slave select, active low, asynchronous.
- sclk  input  1  SPI clock, asynchronous.
- mosi  input  1  SPI serial data in, asynchronous.
- wr  input  1  host command strobe, one clk cycle wide.
- data_in  input  32  host command word, sampled when wr=1.
- data_out  output  32  status and last popped byte.
- full_alarm_led  output  1  high while FIFO is full.
- empty_alarm_led  output  1  high while FIFO is empty.

Behaviour:
- Reset: rst is synchronous, active-high, on the single clock clk. It clears the FIFO pointers and count, the shift register, the bit counter, the overflow flag and the byte register, and reloads the synchronizers to idle (ss=1, sclk=0).
- Output values during reset: data_out = 0x4000_0000 (empty bit set), full_alarm_led=0, empty_alarm_led=1.
- Input sync: ss, sclk and mosi each pass through a 2-flop synchronizer.
- sclk edge detection: a rising edge is synced sclk 0->1 between consecutive clk cycles.
- Receive: while synced ss=0, each sclk rising edge shifts synced mosi into the LSB of the 8-bit shift register. The first bit received ends up as bit 7 (MSB first). The bit counter increments.
- Frame complete: on the 8th bit, the assembled byte is pushed on the next clk and the bit counter returns to 0. Frames are delimited by bit count only, so back-to-back frames with ss held low are valid.
- ss deassertion: synced ss=1 clears the bit counter and discards any partial byte. A new frame starts at the next ss falling edge.
- Push when full: the byte is dropped and the sticky overflow flag is set. FIFO contents are unchanged.
- Command decode (only when wr=1):
  - data_in[31]=1: pop. The FIFO head byte is loaded into data_out[7:0] one clk later and the count decrements.
  - data_in[31]=0: clear the overflow flag. The FIFO is untouched.
  - data_in[30:0] are ignored.
- Pop when empty: ignored; the byte register keeps its previous value.
- Simultaneous push and pop in one cycle: both take effect and the count is unchanged. If the FIFO is full, the pop frees a slot and the push succeeds. If the FIFO is empty, the pop is ignored and the push is stored.
- data_out fields, registered:
  - [31] full.
  - [30] empty.
  - [29] overflow (sticky).
  - [28:18] zero.
  - [17:8] occupancy count, 0..DEPTH.
  - [7:0] last popped byte.
- LEDs: full_alarm_led = (count==DEPTH); empty_alarm_led = (count==0). Both are registered and updated the cycle after the count changes.
- Pointers: read and write pointers are ADDR_W bits wide and wrap modulo DEPTH. The count is ADDR_W+1 bits wide.

Test Plan:
- Reset check: assert rst for several cycles, then release -> data_out=0x4000_0000, empty_alarm_led=1, full_alarm_led=0.
- Single frame:
  - Stimulus: ss low, 8 sclk pulses (50 ns high/low), mosi=0 for bits 1-3 and 1 for bits 4-8.
  - Response: count=1, empty_alarm_led=0.
  - Then pop (wr with data_in=0x8000_0000): data_out[7:0]=0x1F, data_out=0x4000_001F.
- Second frame without raising ss:
  - Stimulus: mosi bits 1,1,1,1,0,0,1,1.
  - Response: byte 0xF3 stored after 0x1F; pops return 0x1F then 0xF3 in order.
- Overflow:
  - Stimulus: 522 consecutive frames with ss held low.
  - Response: count=512, full_alarm_led=1, data_out[31]=1, data_out[29]=1; the last 10 bytes are dropped.
- Drain after full:
  - Stimulus: wr with data_in=0x0000_0000, then two wr pulses with data_in=0x8000_0000.
  - Response: overflow cleared; first pop returns the first received byte with count=511 and full_alarm_led=0; second pop gives count=510.
- Partial frame abort and mid-operation reset:
  - Stimulus: 4 bits, then ss high, then a full frame 0xA5 -> only 0xA5 is stored.
  - Stimulus: rst asserted mid-frame -> FIFO empty and partial bits lost.
